// File: rtl/tms34020_mmtm_seq_pkg.sv
// ============================================================================
// tms34020_pkg : shared types and constants for the MMTM sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package tms34020_pkg;

   localparam int       STEP_BITS_DEFAULT = 32;
   localparam logic [3:0] SP_IDX          = 4'hF;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LDPTR   = 3'd1,
      READ    = 3'd2,
      WREQ    = 3'd3,
      WBPTR   = 3'd4,
      DONE_ST = 3'd5
   } mmtm_state_t;

endpackage

`default_nettype wire

// File: rtl/tms34020_mmtm_seq_prio16.sv
// ============================================================================
// tms34020_prio16 : index of the highest set bit of a 16-bit vector
// Rev 1.0
// ============================================================================
`default_nettype none

module tms34020_prio16 (
   input  logic [15:0] vec_i,
   output logic [3:0]  idx_o,
   output logic        any_o
);

   always_comb begin
      idx_o = 4'd0;
      // Ascending scan: the last hit, i.e. the highest bit, wins.
      for (int i = 0; i < 16; i++) begin
         if (vec_i[i]) idx_o = 4'(i);
      end
   end

   assign any_o = |vec_i;

endmodule

`default_nettype wire

// File: rtl/tms34020_mmtm_seq.sv
// ============================================================================
// tms34020_mmtm_seq : move-multiple-to-memory sequencer (register list to memory)
// Rev 1.0
// ============================================================================
`default_nettype none

module tms34020_mmtm_seq
   import tms34020_pkg::*;
#(
   parameter int STEP_BITS = STEP_BITS_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ce_i,
   input  logic        start_i,
   input  logic [15:0] mask_i,
   input  logic        file_b_i,
   input  logic [3:0]  ptr_a_i,
   output logic [4:0]  rf_ra_a_o,
   input  logic [31:0] rf_ra_q_i,
   output logic [4:0]  rf_wa_a_o,
   output logic [31:0] rf_wa_d_o,
   output logic        rf_wa_we_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic        mem_ack_i,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [31:0] STEP = 32'(STEP_BITS);

   mmtm_state_t state_q, state_d;
   logic [15:0] mask_q, mask_d;
   logic        file_q, file_d;
   logic [3:0]  ptra_q, ptra_d;
   logic [31:0] ptr_q, ptr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;

   logic [3:0]  hi_idx;
   logic        mask_any;

   tms34020_prio16 u_prio (
      .vec_i (mask_q),
      .idx_o (hi_idx),
      .any_o (mask_any)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         mask_q  <= '0;
         file_q  <= 1'b0;
         ptra_q  <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (ce_i) begin
         state_q <= state_d;
         mask_q  <= mask_d;
         file_q  <= file_d;
         ptra_q  <= ptra_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      file_d    = file_q;
      ptra_d    = ptra_q;
      ptr_d     = ptr_q;
      addr_d    = addr_q;
      data_d    = data_q;
      rf_ra_a_o = 5'd0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               mask_d  = mask_i;
               file_d  = file_b_i;
               ptra_d  = ptr_a_i;
               state_d = LDPTR;
            end
         end
         LDPTR: begin
            rf_ra_a_o = {file_q, ptra_q};
            ptr_d     = rf_ra_q_i;
            state_d   = mask_any ? READ : WBPTR;
         end
         READ: begin
            // Predecrement: each store lands one slot below the previous one.
            rf_ra_a_o      = {file_q, hi_idx};
            data_d         = rf_ra_q_i;
            addr_d         = ptr_q - STEP;
            ptr_d          = ptr_q - STEP;
            mask_d[hi_idx] = 1'b0;
            state_d        = WREQ;
         end
         WREQ: begin
            if (mem_ack_i) state_d = mask_any ? READ : WBPTR;
         end
         WBPTR:   state_d = DONE_ST;
         DONE_ST: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_req_o  = (state_q == WREQ);
   assign mem_addr_o = addr_q;
   assign mem_data_o = data_q;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = ce_i && (state_q == DONE_ST);
   assign rf_wa_we_o = ce_i && (state_q == WBPTR);
   assign rf_wa_a_o  = (state_q == WBPTR) ? {file_q, ptra_q} : 5'd0;
   assign rf_wa_d_o  = (state_q == WBPTR) ? ptr_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_tms34020_mmtm_seq.sv
// ============================================================================
// tb_tms34020_mmtm_seq : randomized self-checking bench for the MMTM sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tms34020_mmtm_seq;

   localparam int STEP = 32;

   logic        clk = 1'b0;
   logic        rst, ce, start, file_b, ack;
   logic [15:0] mask;
   logic [3:0]  ptr_a;
   logic [4:0]  rf_ra_a, rf_wa_a;
   logic [31:0] rf_ra_q, rf_wa_d, mem_addr, mem_data;
   logic        rf_wa_we, mem_req, busy, done;

   int checks = 0;
   int errors = 0;

   // Register file model: index 15 is one physical register shared by both files.
   logic [31:0] rf [32];

   always #5 clk = ~clk;

   function automatic int phys(input logic [4:0] a);
      return (a[3:0] == 4'hF) ? 15 : int'(a);
   endfunction

   always_comb rf_ra_q = rf[phys(rf_ra_a)];

   tms34020_mmtm_seq #(.STEP_BITS(STEP)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .ce_i       (ce),
      .start_i    (start),
      .mask_i     (mask),
      .file_b_i   (file_b),
      .ptr_a_i    (ptr_a),
      .rf_ra_a_o  (rf_ra_a),
      .rf_ra_q_i  (rf_ra_q),
      .rf_wa_a_o  (rf_wa_a),
      .rf_wa_d_o  (rf_wa_d),
      .rf_wa_we_o (rf_wa_we),
      .mem_req_o  (mem_req),
      .mem_addr_o (mem_addr),
      .mem_data_o (mem_data),
      .mem_ack_i  (ack),
      .busy_o     (busy),
      .done_o     (done)
   );

   task automatic randomize_rf();
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
   endtask

   // One full instruction; expected stores derive from the list semantics directly.
   task automatic run_seq(input logic [15:0] m, input logic fb, input logic [3:0] pa,
                          input int ce_pct, input int wlo, input int whi,
                          input int exp_first_req, input int exp_done_cyc);
      logic [31:0] exp_a[$], exp_d[$], got_a[$], got_d[$];
      logic [31:0] p, hold_a, hold_d, wb_d;
      logic [4:0]  wb_a;
      logic        hold, seen_done;
      int          wb_cnt, busy_err, stab_err, first_req, done_cyc, wcnt, wtgt;
      p = rf[phys({fb, pa})];
      for (int i = 15; i >= 0; i--) begin
         if (m[i]) begin
            p = p - STEP;
            exp_a.push_back(p);
            exp_d.push_back(rf[phys({fb, 4'(i)})]);
         end
      end
      hold = 1'b0; seen_done = 1'b0; hold_a = '0; hold_d = '0; wb_a = '0; wb_d = '0;
      wb_cnt = 0; busy_err = 0; stab_err = 0; first_req = -1; done_cyc = -1;
      wcnt = 0; wtgt = $urandom_range(wlo, whi);

      @(negedge clk);
      start = 1'b1; mask = m; file_b = fb; ptr_a = pa; ce = 1'b1; ack = 1'($urandom);
      for (int cyc = 1; cyc < 400 && !seen_done; cyc++) begin
         @(negedge clk);
         start  = ($urandom_range(0, 3) == 0);
         mask   = 16'($urandom);
         file_b = 1'($urandom);
         ptr_a  = 4'($urandom);
         ce     = ($urandom_range(0, 99) < ce_pct);
         ack    = mem_req ? (wcnt >= wtgt) : 1'($urandom);
         #1;
         if (!busy) busy_err++;
         if (mem_req && first_req < 0) first_req = cyc;
         if (mem_req && hold && (mem_addr !== hold_a || mem_data !== hold_d)) stab_err++;
         if (mem_req && ce && ack) begin
            got_a.push_back(mem_addr);
            got_d.push_back(mem_data);
            hold = 1'b0; wcnt = 0; wtgt = $urandom_range(wlo, whi);
         end else begin
            hold = mem_req; hold_a = mem_addr; hold_d = mem_data;
            if (mem_req && ce) wcnt++;
         end
         if (rf_wa_we) begin
            wb_cnt++; wb_a = rf_wa_a; wb_d = rf_wa_d;
            rf[phys(rf_wa_a)] = rf_wa_d;
         end
         if (done) begin seen_done = 1'b1; done_cyc = cyc; end
      end
      @(negedge clk);
      start = 1'b0; ce = 1'b1; ack = 1'b0;
      #1;

      checks++;
      if (!seen_done) begin errors++; $display("FAIL seq_done_timeout got none exp DONE mask=%h", m); end
      checks++;
      if (got_a.size() != exp_a.size()) begin
         errors++; $display("FAIL write_count got %0d exp %0d mask=%h", got_a.size(), exp_a.size(), m);
      end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         checks++;
         if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
            errors++;
            $display("FAIL write%0d got (%h,%h) exp (%h,%h)", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
         end
      end
      checks++;
      if (wb_cnt != 1 || wb_a !== {fb, pa} || wb_d !== p) begin
         errors++;
         $display("FAIL ptr_writeback got cnt=%0d a=%h d=%h exp cnt=1 a=%h d=%h", wb_cnt, wb_a, wb_d, {fb, pa}, p);
      end
      checks++;
      if (busy_err != 0 || stab_err != 0) begin
         errors++; $display("FAIL busy_stability got busy_err=%0d stab_err=%0d exp 0 0", busy_err, stab_err);
      end
      checks++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
         errors++; $display("FAIL idle_after got busy=%b req=%b exp 0 0", busy, mem_req);
      end
      if (exp_first_req >= 0) begin
         checks++;
         if (first_req != exp_first_req) begin
            errors++; $display("FAIL first_req_cycle got %0d exp %0d", first_req, exp_first_req);
         end
      end
      if (exp_done_cyc >= 0) begin
         checks++;
         if (done_cyc != exp_done_cyc) begin
            errors++; $display("FAIL done_cycle got %0d exp %0d", done_cyc, exp_done_cyc);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ce = 1'b1; start = 1'b0; mask = '0; file_b = 1'b0; ptr_a = '0; ack = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({rf_ra_a, rf_wa_a, rf_wa_we, mem_req, busy, done} !== '0 ||
          rf_wa_d !== '0 || mem_addr !== '0 || mem_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs got ra=%h wa=%h wd=%h we=%b req=%b a=%h d=%h busy=%b done=%b exp all 0",
                  rf_ra_a, rf_wa_a, rf_wa_d, rf_wa_we, mem_req, mem_addr, mem_data, busy, done);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      randomize_rf();
      rf[14] = 32'h1000;
      run_seq(16'h8001, 1'b0, 4'd14, 100, 1, 1, 3, -1);
      run_seq(16'h0000, 1'b0, 4'd3, 100, 0, 0, -1, 3);
      rf[4] = 32'h20;
      run_seq(16'h0010, 1'b0, 4'd4, 100, 0, 2, 3, -1);
      rf[16 + 5] = 32'h0;
      run_seq(16'h0006, 1'b1, 4'd5, 100, 0, 0, 3, -1);
      run_seq(16'hC000, 1'b1, 4'hF, 100, 0, 1, 3, -1);
   endtask

   task automatic test_ce_and_wait();
      randomize_rf();
      run_seq(16'h0A0A, 1'b0, 4'd2, 50, 10, 10, -1, -1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] ptr_before;
      logic        reached, we_seen;
      randomize_rf();
      ptr_before = rf[7];
      reached = 1'b0; we_seen = 1'b0;
      @(negedge clk);
      start = 1'b1; mask = 16'h00F0; file_b = 1'b0; ptr_a = 4'd7; ce = 1'b1; ack = 1'b0;
      for (int i = 0; i < 12 && !reached; i++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (mem_req) reached = 1'b1;
      end
      rst = 1'b1;
      #1;
      if (rf_wa_we) we_seen = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (!reached || mem_req !== 1'b0 || busy !== 1'b0 || rf_wa_we !== 1'b0 || we_seen || rf[7] !== ptr_before) begin
         errors++;
         $display("FAIL reset_mid got reached=%b req=%b busy=%b we=%b ptr=%h exp 1 0 0 0 %h",
                  reached, mem_req, busy, rf_wa_we, rf[7], ptr_before);
      end
      rst = 1'b0;
      run_seq(16'h00F0, 1'b0, 4'd7, 100, 0, 1, 3, -1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) begin
         logic [15:0] m;
         randomize_rf();
         case ($urandom_range(0, 5))
            0:       m = 16'h0000;
            1:       m = 16'hFFFF;
            default: m = 16'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 31)] = 32'($urandom_range(0, 64));
         run_seq(m, 1'($urandom), 4'($urandom), $urandom_range(40, 100), 0, 3, -1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ce_and_wait();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
